// File: rtl/wb_regfile.sv
// Writeback register file: 32 GPRs plus HI/LO, committed on the clock edge, two async read ports.
// Optional build macro REGFILE_BYPASS_EN forwards the in-flight writeback bundle to all read outputs.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Each GPR is its own flop bank so the whole file can clear in one reset cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_gpr
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_reg
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_q <= '0;
          end else if (wb_wreg && (wb_wd == ADDR_W'(gi))) begin
            r_q <= wb_wdata;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (wb_whilo) begin
      r_hi <= wb_hi;
      r_lo <= wb_lo;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic re, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!rst && (addr != '0) && re) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_wreg && (wb_wd == addr)) begin
        v = wb_wdata;
      end else begin
        v = w_regs[addr];
      end
`else
      v = w_regs[addr];
`endif
    end
    return v;
  endfunction

  assign rdata1 = f_read(re1, raddr1);
  assign rdata2 = f_read(re2, raddr2);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
`ifdef REGFILE_BYPASS_EN
      hi_o = wb_whilo ? wb_hi : r_hi;
      lo_o = wb_whilo ? wb_lo : r_lo;
`else
      hi_o = r_hi;
      lo_o = r_lo;
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table followed by randomized cycles against a reference model.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic        rst;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Reference state: what the architected registers should hold.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;

  function automatic vec_t mk(
    input logic r, input logic wr, input logic [4:0] wd, input logic [31:0] wdat,
    input logic wh, input logic [31:0] h, input logic [31:0] l,
    input logic e_1, input logic [4:0] a1, input logic e_2, input logic [4:0] a2,
    input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xh, input logic [31:0] xl);
    vec_t v;
    v.rst = r; v.wreg = wr; v.wd = wd; v.wdata = wdat;
    v.whilo = wh; v.hi = h; v.lo = l;
    v.re1 = e_1; v.ra1 = a1; v.re2 = e_2; v.ra2 = a2;
    v.e1 = x1; v.e2 = x2; v.ehi = xh; v.elo = xl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; wb_wreg = v.wreg; wb_wd = v.wd; wb_wdata = v.wdata;
    wb_whilo = v.whilo; wb_hi = v.hi; wb_lo = v.lo;
    re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
    if (rst || a == 5'd0 || !re) return 32'h0;
    if (BYP && wb_wreg && wb_wd == a) return wb_wdata;
    return m_regs[a];
  endfunction

  task automatic model_commit();
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) m_regs[wb_wd] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
    end
  endtask

  initial begin
    vec_t v;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;

    // rst wr wd wdata whilo hi lo | re1 ra1 re2 ra2 | e1 e2 ehi elo
    vecs.push_back(mk(1,0,0,0,0,0,0, 1,5,1,5, 0,0,0,0));
    vecs.push_back(mk(0,1,5,32'hDEADBEEF,0,0,0, 1,5,0,0, BYP ? 32'hDEADBEEF : 32'h0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,5,1,5, 32'hDEADBEEF,32'hDEADBEEF,0,0));
    vecs.push_back(mk(1,1,3,32'h55,1,1,2, 1,5,1,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,5,1,3, 0,0,0,0));
    vecs.push_back(mk(0,1,0,32'hFFFFFFFF,0,0,0, 1,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1,31,32'h12345678,0,0,0, 0,31,1,31, 0,BYP ? 32'h12345678 : 32'h0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,31,1,31, 0,32'h12345678,0,0));
    vecs.push_back(mk(0,1,7,32'h1,0,0,0, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,7,32'h2,0,0,0, 1,7,1,7, BYP ? 32'h2 : 32'h1,BYP ? 32'h2 : 32'h1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,7,1,7, 32'h2,32'h2,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hAAAA0000,32'h0000BBBB, 1,31,0,7,
                      32'h12345678,0,BYP ? 32'hAAAA0000 : 32'h0,BYP ? 32'h0000BBBB : 32'h0));
    vecs.push_back(mk(0,0,0,0,0,32'h1111,32'h2222, 0,0,0,0, 0,0,32'hAAAA0000,32'h0000BBBB));
    vecs.push_back(mk(0,1,9,32'hA,0,32'h3333,32'h4444, 1,9,1,7, BYP ? 32'hA : 32'h0,32'h2,32'hAAAA0000,32'h0000BBBB));
    vecs.push_back(mk(0,1,9,32'hB,0,0,0, 1,9,1,9, BYP ? 32'hB : 32'hA,BYP ? 32'hB : 32'hA,32'hAAAA0000,32'h0000BBBB));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,9,1,31, 32'hB,32'h12345678,32'hAAAA0000,32'h0000BBBB));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("vec%0d_rdata1", i), rdata1, v.e1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, v.e2);
      chk($sformatf("vec%0d_hi", i), hi_o, v.ehi);
      chk($sformatf("vec%0d_lo", i), lo_o, v.elo);
      $display("vec %0d rst=%0b wr=%0b wd=%0d r1=%h r2=%h hi=%h lo=%h",
               i, v.rst, v.wreg, v.wd, rdata1, rdata2, hi_o, lo_o);
      @(posedge clk);
      model_commit();
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 39) == 0);
      wb_wreg  = $urandom_range(0, 1) == 1;
      wb_wd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      wb_whilo = $urandom_range(0, 2) == 0;
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = $urandom_range(0, 4) != 0;
      re2      = $urandom_range(0, 4) != 0;
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      chk($sformatf("rnd%0d_rdata1", i), rdata1, model_read(re1, raddr1));
      chk($sformatf("rnd%0d_rdata2", i), rdata2, model_read(re2, raddr2));
      chk($sformatf("rnd%0d_hi", i), hi_o, rst ? 32'h0 : ((BYP && wb_whilo) ? wb_hi : m_hi));
      chk($sformatf("rnd%0d_lo", i), lo_o, rst ? 32'h0 : ((BYP && wb_whilo) ? wb_lo : m_lo));
      $display("rnd %0d rst=%0b wr=%0b wd=%0d a1=%0d a2=%0d r1=%h r2=%h",
               i, rst, wb_wreg, wb_wd, raddr1, raddr2, rdata1, rdata2);
      @(posedge clk);
      model_commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
